merge_memory_banked: RTL and testbench

- Parametrised successor to the two-macro merge.
- Stitches NUM_BANKS single-port-read / single-port-write SRAM macros into one flat address space. The macros use an active-low csb and registered outputs.
- Tracks which bank each read was issued to, across the macro read latency, so returned data is muxed from the correct bank and flagged with r_valid.
- Sits between the wfg pattern/config logic and the sky130 SRAM macros. Also flags same-cycle read/write collisions.

---
 rtl/merge_memory_banked.sv | 110 +++++++++++
 tb/tb_merge_memory_banked.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_memory_banked.sv
// Stitches NUM_BANKS sky130-style SRAM macros into one flat word space.
// Ports: flat r_*/w_* request side, bank_* per-macro side, r_valid/rw_conflict.
module merge_memory_banked #(
  parameter int NUM_BANKS    = 4,
  parameter int BANK_ADDR_W  = 9,
  parameter int DATA_W       = 32,
  parameter int WMASK_W      = 4,
  parameter int READ_LATENCY = 1,
  localparam int BANK_W      = $clog2(NUM_BANKS),
  localparam int ADDR_W      = BANK_ADDR_W + BANK_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             r_csb,
  input  logic [ADDR_W-1:0]                r_addr,
  output logic [DATA_W-1:0]                r_dout,
  output logic                             r_valid,
  input  logic                             w_csb,
  input  logic                             w_web,
  input  logic [WMASK_W-1:0]               w_wmask,
  input  logic [ADDR_W-1:0]                w_addr,
  input  logic [DATA_W-1:0]                w_din,
  output logic [NUM_BANKS-1:0]             bank_r_csb,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_r_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]      bank_r_dout,
  output logic [NUM_BANKS-1:0]             bank_w_csb,
  output logic [NUM_BANKS-1:0]             bank_w_web,
  output logic [NUM_BANKS*WMASK_W-1:0]     bank_w_wmask,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_w_addr,
  output logic [NUM_BANKS*DATA_W-1:0]      bank_w_din,
  output logic                             rw_conflict
);

  logic [BANK_W-1:0]      r_bank;
  logic [BANK_W-1:0]      w_bank;
  logic [BANK_ADDR_W-1:0] r_word;
  logic [BANK_ADDR_W-1:0] w_word;

  assign r_bank = r_addr[ADDR_W-1:BANK_ADDR_W];
  assign w_bank = w_addr[ADDR_W-1:BANK_ADDR_W];
  assign r_word = r_addr[BANK_ADDR_W-1:0];
  assign w_word = w_addr[BANK_ADDR_W-1:0];

  // Unselected banks are parked: csb/web high, everything else zero.
  always_comb begin
    bank_r_csb   = '1;
    bank_r_addr  = '0;
    bank_w_csb   = '1;
    bank_w_web   = '1;
    bank_w_wmask = '0;
    bank_w_addr  = '0;
    bank_w_din   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!r_csb && r_bank == BANK_W'(b)) begin
        bank_r_csb[b] = 1'b0;
        bank_r_addr[b*BANK_ADDR_W +: BANK_ADDR_W] = r_word;
      end
      if (!w_csb && w_bank == BANK_W'(b)) begin
        bank_w_csb[b] = 1'b0;
        bank_w_web[b] = w_web;
        bank_w_wmask[b*WMASK_W +: WMASK_W] = w_wmask;
        bank_w_addr[b*BANK_ADDR_W +: BANK_ADDR_W] = w_word;
        bank_w_din[b*DATA_W +: DATA_W] = w_din;
      end
    end
  end

  // {valid, bank} follows each read through the macro latency.
  logic [READ_LATENCY-1:0]             vld_q;
  logic [READ_LATENCY-1:0][BANK_W-1:0] bnk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      bnk_q <= '0;
    end else begin
      vld_q[0] <= ~r_csb;
      bnk_q[0] <= r_bank;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        bnk_q[i] <= bnk_q[i-1];
      end
    end
  end

  assign r_valid = vld_q[READ_LATENCY-1];

  always_comb begin
    r_dout = '0;
    if (r_valid) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bnk_q[READ_LATENCY-1] == BANK_W'(b))
          r_dout = bank_r_dout[b*DATA_W +: DATA_W];
      end
    end
  end

  logic conf_d;
  logic conf_q;

  assign conf_d = ~r_csb & ~w_csb & ~w_web & (r_addr == w_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conf_q <= 1'b0;
    else        conf_q <= conf_d;
  end

  assign rw_conflict = conf_q;

endmodule

// File: tb/tb_merge_memory_banked.sv
// Bench for merge_memory_banked: a latency-1 and a latency-3 instance
// share stimulus, each with its own macro model and result scoreboard.
module tb_merge_memory_banked;

  localparam int NB  = 4;
  localparam int BAW = 9;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int AW  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  logic r_csb, w_csb, w_web;
  logic [AW-1:0] r_addr, w_addr;
  logic [MW-1:0] w_wmask;
  logic [DW-1:0] w_din;

  logic [DW-1:0]     r_dout1, r_dout3;
  logic              r_valid1, r_valid3, conf1, conf3;
  logic [NB-1:0]     brcsb1, bwcsb1, bwweb1, brcsb3, bwcsb3, bwweb3;
  logic [NB*BAW-1:0] braddr1, bwaddr1, braddr3, bwaddr3;
  logic [NB*DW-1:0]  brdout1, bwdin1, brdout3, bwdin3;
  logic [NB*MW-1:0]  bwmask1, bwmask3;

  merge_memory_banked #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .r_csb(r_csb), .r_addr(r_addr), .r_dout(r_dout1), .r_valid(r_valid1),
    .w_csb(w_csb), .w_web(w_web), .w_wmask(w_wmask), .w_addr(w_addr),
    .w_din(w_din),
    .bank_r_csb(brcsb1), .bank_r_addr(braddr1), .bank_r_dout(brdout1),
    .bank_w_csb(bwcsb1), .bank_w_web(bwweb1), .bank_w_wmask(bwmask1),
    .bank_w_addr(bwaddr1), .bank_w_din(bwdin1), .rw_conflict(conf1)
  );

  merge_memory_banked #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .r_csb(r_csb), .r_addr(r_addr), .r_dout(r_dout3), .r_valid(r_valid3),
    .w_csb(w_csb), .w_web(w_web), .w_wmask(w_wmask), .w_addr(w_addr),
    .w_din(w_din),
    .bank_r_csb(brcsb3), .bank_r_addr(braddr3), .bank_r_dout(brdout3),
    .bank_w_csb(bwcsb3), .bank_w_web(bwweb3), .bank_w_wmask(bwmask3),
    .bank_w_addr(bwaddr3), .bank_w_din(bwdin3), .rw_conflict(conf3)
  );

  // Macro models: registered dout, masked byte writes; the second
  // model adds two extra output register stages.
  logic [DW-1:0] mem1 [NB][512];
  logic [DW-1:0] mem3 [NB][512];
  logic [DW-1:0] d1 [NB];
  logic [DW-1:0] d3a [NB];
  logic [DW-1:0] d3b [NB];
  logic [DW-1:0] d3c [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!brcsb1[b]) d1[b] <= mem1[b][braddr1[b*BAW +: BAW]];
      if (!bwcsb1[b] && !bwweb1[b])
        for (int k = 0; k < MW; k++)
          if (bwmask1[b*MW+k])
            mem1[b][bwaddr1[b*BAW +: BAW]][8*k +: 8] <= bwdin1[b*DW+8*k +: 8];
      if (!brcsb3[b]) d3a[b] <= mem3[b][braddr3[b*BAW +: BAW]];
      d3b[b] <= d3a[b];
      d3c[b] <= d3b[b];
      if (!bwcsb3[b] && !bwweb3[b])
        for (int k = 0; k < MW; k++)
          if (bwmask3[b*MW+k])
            mem3[b][bwaddr3[b*BAW +: BAW]][8*k +: 8] <= bwdin3[b*DW+8*k +: 8];
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_dout
    assign brdout1[b*DW +: DW] = d1[b];
    assign brdout3[b*DW +: DW] = d3c[b];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            chk;
  } sb_t;

  logic [DW-1:0] exp_mem [2048];
  sb_t q1[$];
  sb_t q3[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (r_valid1) begin
      if (q1.size() == 0) chk("spurious_v1", 128'(r_valid1), 128'(0));
      else begin
        e = q1.pop_front();
        chk("lat1", 128'(cyc - e.cyc), 128'(1));
        if (e.chk) chk("data1", 128'(r_dout1), 128'(e.data));
      end
    end else chk("dout_idle1", 128'(r_dout1), 128'(0));
    if (r_valid3) begin
      if (q3.size() == 0) chk("spurious_v3", 128'(r_valid3), 128'(0));
      else begin
        e = q3.pop_front();
        chk("lat3", 128'(cyc - e.cyc), 128'(3));
        if (e.chk) chk("data3", 128'(r_dout3), 128'(e.data));
      end
    end else chk("dout_idle3", 128'(r_dout3), 128'(0));
  end

  task automatic idle();
    r_csb = 1'b1; r_addr = '0;
    w_csb = 1'b1; w_web = 1'b1; w_wmask = '0; w_addr = '0; w_din = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit c);
    r_csb = 1'b0;
    r_addr = a;
    q1.push_back('{exp_mem[a], cyc, c});
    q3.push_back('{exp_mem[a], cyc, c});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [MW-1:0] m);
    w_csb = 1'b0; w_web = 1'b0; w_wmask = m; w_addr = a; w_din = d;
    for (int k = 0; k < MW; k++)
      if (m[k]) exp_mem[a][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rcsb"}, 128'(brcsb1), 128'(4'hF));
    chk({tag, "_wcsb"}, 128'(bwcsb1), 128'(4'hF));
    chk({tag, "_wweb"}, 128'(bwweb1), 128'(4'hF));
    chk({tag, "_raddr"}, 128'(braddr1), 128'(0));
    chk({tag, "_waddr"}, 128'(bwaddr1), 128'(0));
    chk({tag, "_wdin"}, 128'(bwdin1), 128'(0));
    chk({tag, "_wmask"}, 128'(bwmask1), 128'(0));
    chk({tag, "_rvalid"}, 128'(r_valid1), 128'(0));
    chk({tag, "_rdout"}, 128'(r_dout1), 128'(0));
  endtask

  logic [AW-1:0] t1_addr [4] = '{11'h005, 11'h205, 11'h405, 11'h605};
  logic [DW-1:0] t1_data [4] = '{32'hA5A5_0001, 32'hA5A5_0202,
                                 32'hA5A5_0403, 32'hA5A5_0604};

  initial begin
    logic [NB-1:0]     em;
    logic [NB*BAW-1:0] ea;
    logic [NB*DW-1:0]  ed;
    idle();
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_conf1", 128'(conf1), 128'(0));
    chk("rst_conf3", 128'(conf3), 128'(0));
    chk("rst_valid3", 128'(r_valid3), 128'(0));
    chk_idle("rst");
    next();
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      next(); idle();
      wr(t1_addr[i], t1_data[i], 4'hF);
      @(negedge clk);
      em = ~(4'b0001 << i);
      ea = '0; ea[BAW*i +: BAW] = 9'd5;
      ed = '0; ed[DW*i +: DW] = t1_data[i];
      chk("t1_wcsb", 128'(bwcsb1), 128'(em));
      chk("t1_waddr", 128'(bwaddr1), 128'(ea));
      chk("t1_wdin", 128'(bwdin1), 128'(ed));
    end
    for (int i = 0; i < 4; i++) begin
      next(); idle();
      rd(t1_addr[i], 1'b1);
      @(negedge clk);
      em = ~(4'b0001 << i);
      ea = '0; ea[BAW*i +: BAW] = 9'd5;
      chk("t1_rcsb", 128'(brcsb1), 128'(em));
      chk("t1_raddr", 128'(braddr1), 128'(ea));
    end

    next(); idle();
    repeat (4) next();
    @(negedge clk);
    chk_idle("t2");

    next(); idle(); wr(11'h010, 32'hFFFF_FFFF, 4'hF);
    next(); idle(); wr(11'h010, 32'h0000_0000, 4'h2);
    next(); idle(); rd(11'h010, 1'b1);

    next(); idle();
    w_csb = 1'b0; w_web = 1'b1; w_addr = 11'h405;
    w_din = 32'hDEAD_BEEF; w_wmask = 4'hF;
    @(negedge clk);
    chk("nowr_web", 128'(bwweb1), 128'(4'hF));
    chk("nowr_csb", 128'(bwcsb1), 128'(4'b1011));
    next(); idle(); rd(11'h405, 1'b1);

    next(); idle();
    rd(11'h123, 1'b0);
    wr(11'h123, 32'h1234_5678, 4'hF);
    next(); idle();
    @(negedge clk);
    chk("t4_conf1", 128'(conf1), 128'(1));
    chk("t4_conf3", 128'(conf3), 128'(1));
    next();
    @(negedge clk);
    chk("t4_conf_clr", 128'(conf1), 128'(0));
    next(); idle();
    rd(11'h123, 1'b1);
    wr(11'h323, 32'h0BAD_F00D, 4'hF);
    next(); idle();
    @(negedge clk);
    chk("t4_noconf1", 128'(conf1), 128'(0));
    chk("t4_noconf3", 128'(conf3), 128'(0));

    for (int i = 0; i < 10 && (q1.size() != 0 || q3.size() != 0); i++)
      next();

    next(); idle();
    r_csb = 1'b0; r_addr = 11'h001;
    rst1_n = 1'b0;
    next();
    rst3_n = 1'b0;
    r_addr = 11'h601;
    next(); idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_v1", 128'(r_valid1), 128'(0));
      chk("t5_v3", 128'(r_valid3), 128'(0));
      chk("t5_d3", 128'(r_dout3), 128'(0));
    end
    next();
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    repeat (4) next();
    rd(11'h005, 1'b1);

    next(); idle(); rd(11'h605, 1'b1);
    next(); idle(); rd(11'h005, 1'b1);
    next(); idle(); rd(11'h405, 1'b1);
    next(); idle(); rd(11'h205, 1'b1);
    next(); idle();

    for (int i = 0; i < 10 && (q1.size() != 0 || q3.size() != 0); i++)
      next();
    chk("drain1", 128'(q1.size()), 128'(0));
    chk("drain3", 128'(q3.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
